// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU front end.
package cpu_pipe_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_t;

    localparam logic [15:0] BUBBLE_INSTR = 16'h4000;
    localparam logic [3:0]  HALT_OPCODE  = 4'hF;
    localparam logic [15:0] PC_INC       = 16'd2;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/ifid_skid_buf.sv
// Single-entry holding register that parks a fetched instruction while decode is stalled.
module ifid_skid_buf
    import cpu_pipe_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  clear,
    input  ifid_t d,
    output ifid_t q,
    output logic  full
);

    // Clear wins over load so a flush always empties the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            full <= 1'b0;
        end else if (clear) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with PC, single-outstanding imem requests and the IF/ID register.
// Optional performance counters are enabled with IFID_PERF_COUNT_EN.
module if_id_fetch_stage #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] BUBBLE_INSTR = cpu_pipe_pkg::BUBBLE_INSTR,
    parameter logic [3:0]  HALT_OPCODE  = cpu_pipe_pkg::HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc_out,
    output logic [15:0] q_instr,
    output logic [15:0] q_pc_inc,
    output logic        q_valid,
    output logic        q_halt
`ifdef IFID_PERF_COUNT_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] stall_cnt
`endif
);
    import cpu_pipe_pkg::*;

    fetch_state_t state, state_next;
    logic [15:0]  pc, pc_next, pc_plus;
    ifid_t        ifid, ifid_d, buf_q, skid_d, bubble;
    logic         ifid_we, buf_load, buf_clear, buf_full, req;

    assign pc_plus = pc + PC_INC;
    assign bubble  = '{instr: BUBBLE_INSTR, pc_inc: 16'h0000, valid: 1'b0};
    assign skid_d  = '{instr: imem_rdata, pc_inc: pc_plus, valid: 1'b1};

    ifid_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clear (buf_clear),
        .d     (skid_d),
        .q     (buf_q),
        .full  (buf_full)
    );

    // Flush overrides everything; an outstanding request is drained so its stale reply is dropped.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ifid_d     = bubble;
        ifid_we    = 1'b0;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        req        = 1'b0;
        imem_addr  = pc;
        if (flush) begin
            ifid_we    = 1'b1;
            pc_next    = redirect_pc;
            buf_clear  = 1'b1;
            state_next = ((state == ST_WAIT || state == ST_DRAIN) && !imem_rvalid)
                         ? ST_DRAIN : ST_FETCH;
        end else begin
            case (state)
                ST_FETCH: begin
                    req        = 1'b1;
                    state_next = ST_WAIT;
                    ifid_we    = !stall;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            buf_load   = 1'b1;
                            state_next = ST_HOLD;
                        end else begin
                            ifid_we = 1'b1;
                            ifid_d  = skid_d;
                            pc_next = pc_plus;
                            if (imem_rdata[15:12] == HALT_OPCODE) begin
                                state_next = ST_HALTED;
                            end else begin
                                req       = 1'b1;
                                imem_addr = pc_plus;
                            end
                        end
                    end else begin
                        ifid_we = !stall;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_we    = 1'b1;
                        ifid_d     = buf_full ? buf_q : bubble;
                        pc_next    = buf_full ? pc_plus : pc;
                        state_next = (buf_full && buf_q.instr[15:12] == HALT_OPCODE)
                                     ? ST_HALTED : ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    ifid_we = !stall;
                    if (imem_rvalid) state_next = ST_FETCH;
                end
                ST_HALTED: begin
                    ifid_we = !stall;
                end
                default: state_next = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            ifid  <= bubble;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (ifid_we) ifid <= ifid_d;
        end
    end

    assign imem_req = req & ~rst;
    assign pc_out   = pc;
    assign q_instr  = ifid.instr;
    assign q_pc_inc = ifid.pc_inc;
    assign q_valid  = ifid.valid;
    assign q_halt   = ifid.valid && (ifid.instr[15:12] == HALT_OPCODE);

`ifdef IFID_PERF_COUNT_EN
    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= 32'h0;
            stall_cnt  <= 32'h0;
        end else begin
            if (ifid_we && !ifid_d.valid && bubble_cnt != 32'hFFFF_FFFF)
                bubble_cnt <= bubble_cnt + 32'd1;
            if (stall && state != ST_HALTED && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: vector table, memory model and IF/ID scoreboard.
module tb_if_id_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_rvalid;
    logic        stall;
    logic        flush;
    logic [15:0] redirect_pc;
    logic [15:0] pc_out;
    logic [15:0] q_instr;
    logic [15:0] q_pc_inc;
    logic        q_valid;
    logic        q_halt;

    if_id_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .pc_out      (pc_out),
        .q_instr     (q_instr),
        .q_pc_inc    (q_pc_inc),
        .q_valid     (q_valid),
        .q_halt      (q_halt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
    } sb_t;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [15:0] redir;
        int          lat;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_qv;
        logic [15:0] exp_qi;
        logic [15:0] exp_qp;
        logic [15:0] exp_pc;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    sb_t         sb_q[$];
    logic [15:0] mem [logic [15:0]];
    logic        pend_valid = 1'b0;
    logic        pend_stale = 1'b0;
    logic [15:0] pend_addr  = 16'h0;
    int          pend_cnt   = 0;
    logic        prev_hold  = 1'b1;
    vec_t        vecs [14];

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: check IF/ID against the scoreboard, drive inputs, model memory, sample requests.
    task automatic applyStimulus(input logic s, input logic f, input logic [15:0] rp, input int lat);
        sb_t exp_item;
        @(negedge clk);
        if (!prev_hold && q_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_underflow", q_instr, 16'hxxxx);
            end else begin
                exp_item = sb_q.pop_front();
                checkOutput("sb_instr", q_instr, exp_item.instr);
                checkOutput("sb_pc_inc", q_pc_inc, exp_item.pc_inc);
            end
        end
        prev_hold   = s | f;
        stall       = s;
        flush       = f;
        redirect_pc = rp;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        if (f) sb_q.delete();
        if (pend_valid) begin
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_rd(pend_addr);
                pend_valid  = 1'b0;
                if (!pend_stale && !f)
                    sb_q.push_back('{instr: imem_rdata, pc_inc: pend_addr + 16'd2});
            end else begin
                pend_cnt--;
                if (f) pend_stale = 1'b1;
            end
        end
        #1;
        if (imem_req) begin
            checkOutput("single_outstanding", {15'b0, pend_valid}, 16'h0000);
            pend_valid = 1'b1;
            pend_stale = 1'b0;
            pend_addr  = imem_addr;
            pend_cnt   = lat - 1;
        end
    endtask

    task automatic resetMemory();
        pend_valid = 1'b0;
        pend_stale = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        sb_q.delete();
        prev_hold = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req"}, {15'b0, imem_req}, 16'h0000);
        checkOutput({tag, "_pc"}, pc_out, 16'h0000);
        checkOutput({tag, "_qv"}, {15'b0, q_valid}, 16'h0000);
        checkOutput({tag, "_qi"}, q_instr, 16'h4000);
        checkOutput({tag, "_qp"}, q_pc_inc, 16'h0000);
        checkOutput({tag, "_halt"}, {15'b0, q_halt}, 16'h0000);
    endtask

    initial begin
        mem[16'h0000] = 16'h1123;
        mem[16'h0002] = 16'h2456;
        mem[16'h0004] = 16'h3789;
        mem[16'h0006] = 16'h5555;
        mem[16'h0008] = 16'hF000;
        mem[16'h0020] = 16'h1ABC;
        mem[16'h0022] = 16'h2BCD;
        mem[16'h0040] = 16'h6ABC;
        mem[16'h0042] = 16'h7DEF;
        mem[16'hFFFE] = 16'h3CDE;

        // stall flush redir lat | req addr | qv qi qp | pc
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0000, 1'b0, 16'h4000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0002, 1'b0, 16'h4000, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0004, 1'b1, 16'h1123, 16'h0002, 16'h0002};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1, 1'b0, 16'h0000, 1'b1, 16'h2456, 16'h0004, 16'h0004};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1, 1'b0, 16'h0000, 1'b1, 16'h2456, 16'h0004, 16'h0004};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1, 1'b0, 16'h0000, 1'b1, 16'h2456, 16'h0004, 16'h0004};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 2, 1'b0, 16'h0000, 1'b1, 16'h2456, 16'h0004, 16'h0004};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 2, 1'b1, 16'h0006, 1'b1, 16'h3789, 16'h0006, 16'h0006};
        vecs[8]  = '{1'b0, 1'b1, 16'h0040, 2, 1'b0, 16'h0000, 1'b0, 16'h4000, 16'h0000, 16'h0006};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 2, 1'b0, 16'h0000, 1'b0, 16'h4000, 16'h0000, 16'h0040};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 2, 1'b1, 16'h0040, 1'b0, 16'h4000, 16'h0000, 16'h0040};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1, 1'b0, 16'h0000, 1'b0, 16'h4000, 16'h0000, 16'h0040};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0042, 1'b0, 16'h4000, 16'h0000, 16'h0040};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1, 1'b1, 16'h0044, 1'b1, 16'h6ABC, 16'h0042, 16'h0042};

        rst         = 1'b1;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_pc = 16'h0000;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].redir, vecs[i].lat);
            checkOutput($sformatf("v%0d_req", i), {15'b0, imem_req}, {15'b0, vecs[i].exp_req});
            if (vecs[i].exp_req)
                checkOutput($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            checkOutput($sformatf("v%0d_qv", i), {15'b0, q_valid}, {15'b0, vecs[i].exp_qv});
            checkOutput($sformatf("v%0d_qi", i), q_instr, vecs[i].exp_qi);
            checkOutput($sformatf("v%0d_qp", i), q_pc_inc, vecs[i].exp_qp);
            checkOutput($sformatf("v%0d_pc", i), pc_out, vecs[i].exp_pc);
        end

        // Flush and stall together while a response arrives: flush wins.
        applyStimulus(1'b1, 1'b1, 16'h0008, 1);
        checkOutput("fs_req", {15'b0, imem_req}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1);
        checkOutput("fs_qv", {15'b0, q_valid}, 16'h0000);
        checkOutput("fs_qi", q_instr, 16'h4000);
        checkOutput("fs_pc", pc_out, 16'h0008);
        checkOutput("fs_req2", {15'b0, imem_req}, 16'h0001);
        checkOutput("fs_addr", imem_addr, 16'h0008);

        // Halt fetched at pc 8 stops requests until a flush.
        applyStimulus(1'b0, 1'b0, 16'h0000, 1);
        checkOutput("halt_noreq", {15'b0, imem_req}, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1);
        checkOutput("halt_flag", {15'b0, q_halt}, 16'h0001);
        checkOutput("halt_pc", pc_out, 16'h000A);
        checkOutput("halt_noreq2", {15'b0, imem_req}, 16'h0000);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 1);
            checkOutput($sformatf("halted%0d_req", k), {15'b0, imem_req}, 16'h0000);
            checkOutput($sformatf("halted%0d_qv", k), {15'b0, q_valid}, 16'h0000);
            checkOutput($sformatf("halted%0d_pc", k), pc_out, 16'h000A);
        end
        applyStimulus(1'b0, 1'b1, 16'h0020, 1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1);
        checkOutput("resume_req", {15'b0, imem_req}, 16'h0001);
        checkOutput("resume_addr", imem_addr, 16'h0020);
        checkOutput("resume_pc", pc_out, 16'h0020);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1);
        checkOutput("resume_addr2", imem_addr, 16'h0022);

        // PC wrap from 16'hFFFE.
        applyStimulus(1'b0, 1'b1, 16'hFFFE, 1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1);
        checkOutput("wrap_addr", imem_addr, 16'hFFFE);
        checkOutput("wrap_pc", pc_out, 16'hFFFE);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1);
        checkOutput("wrap_req", {15'b0, imem_req}, 16'h0001);
        checkOutput("wrap_next_addr", imem_addr, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 3);
        checkOutput("wrap_qi", q_instr, 16'h3CDE);
        checkOutput("wrap_qp", q_pc_inc, 16'h0000);
        checkOutput("wrap_pc2", pc_out, 16'h0000);
        checkOutput("wrap_addr3", imem_addr, 16'h0002);

        // Reset asserted while a request is outstanding.
        @(negedge clk);
        rst = 1'b1;
        resetMemory();
        #1;
        checkResetOutputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1);
        checkOutput("post_rst_req", {15'b0, imem_req}, 16'h0001);
        checkOutput("post_rst_addr", imem_addr, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
